// File: rtl/dpi_pkg.sv
// dpi_pkg: shared state encoding, widths and default timing for the DPI stream sequencer
package dpi_pkg;
  localparam int SID_W = 6;
  localparam int NUM_SID = 1 << SID_W;
  localparam int NUM_RE_DEF = 8;
  localparam int LOAD_GAP_DEF = 2;
  localparam int DRAIN_GAP_DEF = 3;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP} state_e;
  // Terminal count for a phase lasting n cycles, with the counter starting at zero on entry.
  function automatic logic [CNT_W-1:0] last_cnt(input int n);
    return CNT_W'(n - 1);
  endfunction
endpackage

// File: rtl/dpi_stream_cfg_mem.sv
// dpi_stream_cfg_mem: per-stream matcher enable masks, synchronous write and asynchronous read
module dpi_stream_cfg_mem
  import dpi_pkg::*;
#(
  parameter int NUM_RE = NUM_RE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SID_W-1:0]  waddr,
  input  logic [NUM_RE-1:0] wdata,
  input  logic [SID_W-1:0]  raddr,
  output logic [NUM_RE-1:0] rdata
);
  logic [NUM_RE-1:0] mem_q [NUM_SID];
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: frames each packet as load/gap/stream/drain/eop for NUM_RE parallel
// regex matchers and returns their fired flags as one result per packet.
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int NUM_RE = NUM_RE_DEF,
  parameter int LOAD_GAP = LOAD_GAP_DEF,
  parameter int DRAIN_GAP = DRAIN_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [7:0]        in_data,
  input  logic [SID_W-1:0]  in_sid,
  output logic              in_ready,
  input  logic              cfg_we,
  input  logic [SID_W-1:0]  cfg_addr,
  input  logic [NUM_RE-1:0] cfg_wdata,
  input  logic              cfg_clr_seen,
  output logic              load_state,
  output logic              new_stream_id,
  output logic              char_in_vld,
  output logic              eop,
  output logic [7:0]        char_in,
  output logic [SID_W-1:0]  stream_id,
  output logic [NUM_RE-1:0] enable,
  input  logic [NUM_RE-1:0] fired,
  output logic              res_vld,
  output logic [SID_W-1:0]  res_sid,
  output logic [NUM_RE-1:0] res_fired,
  output logic              err_orphan
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SID-1:0] seen_q, seen_d;
  logic [SID_W-1:0] sid_q, res_sid_q;
  logic [NUM_RE-1:0] mask_q, rd_mask, res_fired_q;
  logic [7:0] sop_byte_q, char_q;
  logic sop_eop_q, char_vld_q, err_q, res_vld_q;
  logic accept, sop_take, stream_beat, emit_sop, drain_done;

  dpi_stream_cfg_mem #(.NUM_RE(NUM_RE)) u_cfg_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (in_sid),
    .rdata (rd_mask)
  );

  assign accept = in_vld && in_ready;
  assign sop_take = accept && in_sop && state_q == S_IDLE;
  assign stream_beat = accept && !in_sop && state_q == S_STREAM;
  // With a single-cycle load gap the sop byte leaves straight out of LOAD.
  assign emit_sop = (state_q == S_LOAD && LOAD_GAP == 1) ||
                    (state_q == S_GAP && cnt_q == last_cnt(LOAD_GAP - 1));
  assign drain_done = state_q == S_DRAIN && cnt_q == last_cnt(DRAIN_GAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        state_d = sop_take ? S_LOAD : S_IDLE;
      S_LOAD, S_GAP: state_d = emit_sop ? (sop_eop_q ? S_DRAIN : S_STREAM) : S_GAP;
      S_STREAM:      state_d = accept && (in_eop || in_sop) ? S_DRAIN : S_STREAM;
      S_DRAIN:       state_d = drain_done ? S_EOP : S_DRAIN;
      default:       state_d = S_IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    in_ready = !rst && (state_q == S_IDLE || state_q == S_STREAM);
    load_state = !rst && state_q == S_LOAD;
    new_stream_id = load_state && !seen_q[sid_q];
    eop = !rst && state_q == S_EOP;
    seen_d = cfg_clr_seen ? '0 : seen_q;
    if (load_state) seen_d[sid_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= '0;
      sid_q <= '0;
      mask_q <= '0;
      sop_byte_q <= '0;
      sop_eop_q <= 1'b0;
      char_q <= '0;
      char_vld_q <= 1'b0;
      err_q <= 1'b0;
      res_vld_q <= 1'b0;
      res_sid_q <= '0;
      res_fired_q <= '0;
    end else begin
      seen_q <= seen_d;
      if (sop_take) begin
        sid_q <= in_sid;
        mask_q <= rd_mask;
        sop_byte_q <= in_data;
        sop_eop_q <= in_eop;
      end
      char_vld_q <= emit_sop || stream_beat;
      if (emit_sop) char_q <= sop_byte_q;
      else if (stream_beat) char_q <= in_data;
      // A sop inside a packet truncates it and is reported like an orphan in IDLE.
      err_q <= accept && (state_q == S_IDLE ? !in_sop : in_sop);
      res_vld_q <= state_q == S_EOP;
      if (state_q == S_EOP) begin
        res_sid_q <= sid_q;
        res_fired_q <= fired;
      end
    end
  end

  assign char_in = char_q;
  assign char_in_vld = char_vld_q;
  assign stream_id = sid_q;
  assign enable = mask_q;
  assign res_vld = res_vld_q;
  assign res_sid = res_sid_q;
  assign res_fired = res_fired_q;
  assign err_orphan = err_q;
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer: directed and randomized packets checked against a per-packet timeline model
module tb_dpi_stream_sequencer;
  localparam int NRE = 8;
  localparam int LG = 2;
  localparam int DG = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0] in_data = '0;
  logic [5:0] in_sid = '0;
  logic in_ready;
  logic cfg_we = 1'b0, cfg_clr_seen = 1'b0;
  logic [5:0] cfg_addr = '0;
  logic [NRE-1:0] cfg_wdata = '0;
  logic load_state, new_stream_id, char_in_vld, eop;
  logic [7:0] char_in;
  logic [5:0] stream_id, res_sid;
  logic [NRE-1:0] enable, res_fired;
  logic [NRE-1:0] fired = '0;
  logic res_vld, err_orphan;

  logic [NRE-1:0] mask_m [64];
  bit seen_m [64];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dpi_stream_sequencer #(.NUM_RE(NRE), .LOAD_GAP(LG), .DRAIN_GAP(DG)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_vld        (in_vld),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_data       (in_data),
    .in_sid        (in_sid),
    .in_ready      (in_ready),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_clr_seen  (cfg_clr_seen),
    .load_state    (load_state),
    .new_stream_id (new_stream_id),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .char_in       (char_in),
    .stream_id     (stream_id),
    .enable        (enable),
    .fired         (fired),
    .res_vld       (res_vld),
    .res_sid       (res_sid),
    .res_fired     (res_fired),
    .err_orphan    (err_orphan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d, input logic [5:0] id);
    in_vld = v;
    in_sop = s;
    in_eop = e;
    in_data = d;
    in_sid = id;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [NRE-1:0] m);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = m;
    @(negedge clk);
    cfg_we = 1'b0;
    mask_m[a] = m;
  endtask

  task automatic clr_seen();
    @(negedge clk);
    cfg_clr_seen = 1'b1;
    @(negedge clk);
    cfg_clr_seen = 1'b0;
    for (int i = 0; i < 64; i++) seen_m[i] = 1'b0;
  endtask

  // One packet of len bytes; trunc appends a sop beat that must end it early.
  task automatic pkt(input logic [5:0] sid, input int len, input logic [NRE-1:0] fv, input int gap_pct,
                     input bit trunc, input bit mid_cfg, input logic [NRE-1:0] mid_mask);
    logic [7:0] b [$];
    logic [NRE-1:0] exp_en;
    bit exp_new;
    int n;
    int i;
    for (int k = 0; k < len; k++) b.push_back(8'($urandom));
    n = len + int'(trunc);
    exp_en = mask_m[sid];
    exp_new = !seen_m[sid];
    seen_m[sid] = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_res_vld", res_vld, 0);
    drive(1, 1, n == 1, b[0], sid);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 6'h00);
    chk("load_state", load_state, 1);
    chk("new_stream_id", new_stream_id, exp_new);
    chk("load_sid", stream_id, sid);
    chk("load_enable", enable, exp_en);
    chk("load_ready", in_ready, 0);
    chk("load_err", err_orphan, 0);
    if (mid_cfg) begin
      cfg_we = 1'b1;
      cfg_addr = sid;
      cfg_wdata = mid_mask;
      mask_m[sid] = mid_mask;
    end
    for (int g = 1; g < LG; g++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      chk("gap_ready", in_ready, 0);
      chk("gap_vld", char_in_vld, 0);
      chk("gap_load", load_state, 0);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    chk("first_vld", char_in_vld, 1);
    chk("first_char", char_in, b[0]);
    i = 1;
    while (i < n) begin
      chk("stream_ready", in_ready, 1);
      chk("stream_eop", eop, 0);
      if ($urandom_range(99) < gap_pct) begin
        @(negedge clk);
        chk("stream_idle_vld", char_in_vld, 0);
      end else if (i == len) begin
        drive(1, 1, 0, 8'($urandom), 6'($urandom));
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 6'h00);
        chk("trunc_vld", char_in_vld, 0);
        chk("trunc_err", err_orphan, 1);
        i++;
      end else begin
        drive(1, 0, i == len - 1 && !trunc, b[i], 6'($urandom));
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 6'h00);
        chk("stream_vld", char_in_vld, 1);
        chk("stream_char", char_in, b[i]);
        i++;
      end
    end
    chk("drain_ready", in_ready, 0);
    for (int d = 1; d < DG; d++) begin
      @(negedge clk);
      chk("drain_vld", char_in_vld, 0);
      chk("drain_eop", eop, 0);
      chk("drain_ready", in_ready, 0);
      chk("drain_err", err_orphan, 0);
    end
    @(negedge clk);
    fired = fv;
    chk("eop", eop, 1);
    chk("eop_sid", stream_id, sid);
    chk("eop_enable", enable, exp_en);
    chk("eop_vld", char_in_vld, 0);
    @(negedge clk);
    fired = '0;
    chk("res_vld", res_vld, 1);
    chk("res_sid", res_sid, sid);
    chk("res_fired", res_fired, fv);
    chk("post_eop", eop, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 64; k++) begin
      mask_m[k] = '0;
      seen_m[k] = 1'b0;
    end
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    @(negedge clk);
    chk("rst_ready2", in_ready, 0);
    chk("rst_load", load_state, 0);
    chk("rst_eop", eop, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_err", err_orphan, 0);
    chk("rst_char_vld", char_in_vld, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    cfg_write(6'd5, 8'h01);
    pkt(6'd5, 2, 8'h00, 0, 0, 0, 8'h00);
    pkt(6'd5, 3, 8'h03, 0, 0, 0, 8'h00);
    clr_seen();
    pkt(6'd5, 2, 8'h00, 0, 0, 0, 8'h00);
    pkt(6'd63, 1, 8'h80, 0, 0, 0, 8'h00);
    cfg_write(6'd7, 8'h0F);
    pkt(6'd7, 4, 8'h01, 0, 0, 1, 8'hF0);
    pkt(6'd7, 2, 8'h02, 0, 0, 0, 8'h00);

    @(negedge clk);
    drive(1, 0, 0, 8'h55, 6'd3);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 6'h00);
    chk("orphan_err", err_orphan, 1);
    chk("orphan_load", load_state, 0);
    chk("orphan_ready", in_ready, 1);
    @(negedge clk);
    chk("orphan_err_clear", err_orphan, 0);
    chk("orphan_noload", load_state, 0);

    pkt(6'd9, 3, 8'h11, 0, 1, 0, 8'h00);

    cfg_write(6'd12, 8'h3C);
    @(negedge clk);
    drive(1, 1, 0, 8'hA1, 6'd12);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 6'h00);
    chk("rm_load", load_state, 1);
    repeat (LG) @(negedge clk);
    chk("rm_stream_vld", char_in_vld, 1);
    chk("rm_stream_char", char_in, 8'hA1);
    chk("rm_stream_ready", in_ready, 1);
    drive(1, 0, 0, 8'hB2, 6'd0);
    rst = 1'b1;
    #1;
    chk("rm_rst_ready", in_ready, 0);
    chk("rm_rst_eop", eop, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 8'h00, 6'h00);
    #1;
    chk("rm_idle_ready", in_ready, 1);
    chk("rm_idle_vld", char_in_vld, 0);
    chk("rm_idle_load", load_state, 0);
    chk("rm_idle_enable", enable, 0);
    for (int k = 0; k < 64; k++) begin
      mask_m[k] = '0;
      seen_m[k] = 1'b0;
    end
    repeat (6) begin
      @(negedge clk);
      chk("rm_no_eop", eop, 0);
      chk("rm_no_res", res_vld, 0);
    end
    pkt(6'd12, 3, 8'h5A, 0, 0, 0, 8'h00);

    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(3) == 0) cfg_write(6'($urandom_range(7)), 8'($urandom));
      if ($urandom_range(9) == 0) clr_seen();
      pkt(6'($urandom_range(7)), int'($urandom_range(6, 1)), 8'($urandom), 30,
          $urandom_range(5) == 0, $urandom_range(4) == 0, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
